// File: rtl/misao_pkg.sv
// Shared types for the MISA-O shadow-register stack: op codes, FSM states, default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package misao_pkg;

    localparam int RS_DEPTH_DEFAULT = 4;

    // Management op codes carried on op_code; 6 and 7 are reserved and act as NOP.
    typedef enum logic [2:0] {
        RS_NOP    = 3'd0,
        RS_SWAP   = 3'd1,
        RS_ROT_UP = 3'd2,
        RS_ROT_DN = 3'd3,
        RS_ROT_N  = 3'd4,
        RS_CLR    = 3'd5
    } rs_op_e;

    typedef enum logic {
        RS_IDLE  = 1'b0,
        RS_CLEAR = 1'b1
    } rs_state_e;

endpackage

// File: rtl/misao_rs_ptr.sv
// Base pointer of the register stack plus logical-to-physical index adder.
// Latency: pointer updates on the clock edge; pidx is combinational from the registered base.
// Backpressure: none; the owner decides when to update.
module misao_rs_ptr #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [CNT_W-1:0] add_val,
    input  logic [CNT_W-1:0] lidx,
    output logic [CNT_W-1:0] base,
    output logic [CNT_W-1:0] pidx
);

    logic [CNT_W-1:0] base_d;
    logic [CNT_W-1:0] base_q;

    // Next base: clear wins over an add; additions wrap naturally at CNT_W bits.
    always_comb begin
        base_d = base_q;
        if (clr) begin
            base_d = '0;
        end else if (add_en) begin
            base_d = base_q + add_val;
        end
    end

    // Base pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign base = base_q;
    assign pidx = base_q + lidx;

endmodule

// File: rtl/misao_reg_stack.sv
// Parametrised shadow-register stack (SWAP / rotate / rotate-by-N / bulk clear); optional parity via MISAO_RSTACK_PARITY_EN.
// Latency: state updates at the accept edge, res_valid one cycle later; CLR occupies DEPTH cycles.
// Backpressure: op_ready low while CLR walks the entries; a held request is accepted once it completes.
module misao_reg_stack
    import misao_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = RS_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [CNT_W-1:0] op_arg,
    input  logic             lk16,
    input  logic [WIDTH-1:0] acc_in,
    output logic             res_valid,
    output logic             res_write,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] top_data,
    output logic             busy
`ifdef MISAO_RSTACK_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    rs_state_e        state_d, state_q;
    logic [CNT_W-1:0] clr_cnt_d, clr_cnt_q;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             res_valid_d, res_valid_q;
    logic             res_write_d, res_write_q;
    logic [WIDTH-1:0] res_data_d, res_data_q;
`ifdef MISAO_RSTACK_PARITY_EN
    logic             par_d [DEPTH];
    logic             par_q [DEPTH];
    logic             parity_err_d, parity_err_q;
`endif

    logic             accept;
    logic             ptr_clr;
    logic             ptr_add_en;
    logic [CNT_W-1:0] ptr_add_val;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] top_idx;

    misao_rs_ptr #(
        .CNT_W (CNT_W)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ptr_clr),
        .add_en  (ptr_add_en),
        .add_val (ptr_add_val),
        .lidx    ('0),
        .base    (base),
        .pidx    (top_idx)
    );

    assign op_ready = (state_q == RS_IDLE);
    assign busy     = (state_q == RS_CLEAR);
    assign accept   = op_valid && op_ready;

    // Op decode, clear walk and response generation; all state moves at the accept edge.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        mem_d       = mem_q;
        res_valid_d = 1'b0;
        res_write_d = 1'b0;
        res_data_d  = res_data_q;
        ptr_clr     = 1'b0;
        ptr_add_en  = 1'b0;
        ptr_add_val = '0;
`ifdef MISAO_RSTACK_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        unique case (state_q)
            RS_IDLE: begin
                if (accept) begin
                    // Every op except CLR answers on the next cycle.
                    res_valid_d = 1'b1;
                    case (op_code)
                        RS_SWAP: begin
                            mem_d[top_idx] = acc_in;
                            res_data_d     = mem_q[top_idx];
                            res_write_d    = 1'b1;
`ifdef MISAO_RSTACK_PARITY_EN
                            par_d[top_idx] = ^acc_in;
                            if ((^mem_q[top_idx]) != par_q[top_idx]) begin
                                parity_err_d = 1'b1;
                            end
`endif
                        end
                        RS_ROT_UP: begin
                            ptr_add_en  = 1'b1;
                            ptr_add_val = CNT_W'(1);
                        end
                        RS_ROT_DN: begin
                            // In LK16 link mode the downward rotate is suppressed.
                            ptr_add_en  = !lk16;
                            ptr_add_val = '1;
                        end
                        RS_ROT_N: begin
                            ptr_add_en  = 1'b1;
                            ptr_add_val = op_arg;
                        end
                        RS_CLR: begin
                            state_d     = RS_CLEAR;
                            clr_cnt_d   = '0;
                            res_valid_d = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            RS_CLEAR: begin
                mem_d[clr_cnt_q] = '0;
`ifdef MISAO_RSTACK_PARITY_EN
                par_d[clr_cnt_q] = 1'b0;
`endif
                clr_cnt_d = clr_cnt_q + CNT_W'(1);
                if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
                    ptr_clr     = 1'b1;
                    state_d     = RS_IDLE;
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase
    end

    // State, storage and response registers; rst overrides everything including an active clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RS_IDLE;
            clr_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            res_write_q <= 1'b0;
            res_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef MISAO_RSTACK_PARITY_EN
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            res_valid_q <= res_valid_d;
            res_write_q <= res_write_d;
            res_data_q  <= res_data_d;
            mem_q       <= mem_d;
`ifdef MISAO_RSTACK_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_write = res_write_q;
    assign res_data  = res_data_q;
    assign top_data  = mem_q[top_idx];
`ifdef MISAO_RSTACK_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_misao_reg_stack.sv
// Directed bench for misao_reg_stack (WIDTH=16, DEPTH=4): SWAP, rotates, LK16 suppression, CLR walk and reset abort.
// Inputs change #1 after the rising edge; outputs are checked at the same point, after the edge that produced them.
// Parity checks are compiled in only with MISAO_RSTACK_PARITY_EN.
module tb_misao_reg_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [CNT_W-1:0] op_arg;
    logic             lk16;
    logic [WIDTH-1:0] acc_in;
    logic             res_valid;
    logic             res_write;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] top_data;
    logic             busy;
`ifdef MISAO_RSTACK_PARITY_EN
    logic             parity_err;
`endif

    int tests;
    int fails;

    misao_reg_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_arg    (op_arg),
        .lk16      (lk16),
        .acc_in    (acc_in),
        .res_valid (res_valid),
        .res_write (res_write),
        .res_data  (res_data),
        .top_data  (top_data),
        .busy      (busy)
`ifdef MISAO_RSTACK_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for one edge (block is known to be idle) and leave it deasserted afterwards.
    task automatic issue(input logic [2:0] code, input logic [CNT_W-1:0] arg,
                         input logic lk, input logic [WIDTH-1:0] acc);
        op_valid = 1'b1;
        op_code  = code;
        op_arg   = arg;
        lk16     = lk;
        acc_in   = acc;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycle();
        idle_cycle();
        rst = 1'b0;
        tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        tests++; if (res_write !== 1'b0) begin fails++; $display("FAIL reset_res_write got %b want 0", res_write); end
        tests++; if (res_data !== 16'h0000) begin fails++; $display("FAIL reset_res_data got %h want 0000", res_data); end
        tests++; if (top_data !== 16'h0000) begin fails++; $display("FAIL reset_top_data got %h want 0000", top_data); end
    endtask

    task automatic test_swap();
        issue(3'd1, 2'd0, 1'b0, 16'hAAA1);
        tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL swap1_valid got %b want 1", res_valid); end
        tests++; if (res_write !== 1'b1) begin fails++; $display("FAIL swap1_write got %b want 1", res_write); end
        tests++; if (res_data !== 16'h0000) begin fails++; $display("FAIL swap1_data got %h want 0000", res_data); end
        tests++; if (top_data !== 16'hAAA1) begin fails++; $display("FAIL swap1_top got %h want AAA1", top_data); end
        issue(3'd1, 2'd0, 1'b0, 16'h0002);
        tests++; if (res_data !== 16'hAAA1) begin fails++; $display("FAIL swap2_data got %h want AAA1", res_data); end
        tests++; if (top_data !== 16'h0002) begin fails++; $display("FAIL swap2_top got %h want 0002", top_data); end
        idle_cycle();
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL swap_pulse_len got %b want 0", res_valid); end
    endtask

    task automatic test_rotate();
        logic [WIDTH-1:0] vals [4];
        logic [WIDTH-1:0] old  [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        old[0]  = 16'h0002; old[1]  = 16'h0000; old[2]  = 16'h0000; old[3]  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            issue(3'd1, 2'd0, 1'b0, vals[i]);
            tests++; if (res_data !== old[i]) begin fails++; $display("FAIL load_swap%0d got %h want %h", i, res_data, old[i]); end
            issue(3'd2, 2'd0, 1'b0, 16'h0000);
        end
        tests++; if (top_data !== 16'h1111) begin fails++; $display("FAIL load_top got %h want 1111", top_data); end
        issue(3'd2, 2'd0, 1'b0, 16'h0000);
        tests++; if (top_data !== 16'h2222) begin fails++; $display("FAIL rot_up_top got %h want 2222", top_data); end
        tests++; if (res_valid !== 1'b1 || res_write !== 1'b0) begin fails++; $display("FAIL rot_up_resp got v=%b w=%b want v=1 w=0", res_valid, res_write); end
        issue(3'd3, 2'd0, 1'b0, 16'h0000);
        tests++; if (top_data !== 16'h1111) begin fails++; $display("FAIL rot_dn_top got %h want 1111", top_data); end
    endtask

    task automatic test_lk16();
        issue(3'd1, 2'd0, 1'b0, 16'h0005);
        tests++; if (res_data !== 16'h1111) begin fails++; $display("FAIL lk_swap_data got %h want 1111", res_data); end
        issue(3'd3, 2'd0, 1'b1, 16'h0000);
        tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL lk_rot_dn_valid got %b want 1", res_valid); end
        tests++; if (top_data !== 16'h0005) begin fails++; $display("FAIL lk_rot_dn_top got %h want 0005", top_data); end
        issue(3'd1, 2'd0, 1'b0, 16'h1111);
        tests++; if (res_data !== 16'h0005) begin fails++; $display("FAIL lk_restore_data got %h want 0005", res_data); end
    endtask

    task automatic test_rot_n();
        issue(3'd4, 2'd3, 1'b0, 16'h0000);
        tests++; if (top_data !== 16'h4444) begin fails++; $display("FAIL rot_n3_top got %h want 4444", top_data); end
        issue(3'd4, 2'd0, 1'b0, 16'h0000);
        tests++; if (top_data !== 16'h4444) begin fails++; $display("FAIL rot_n0_top got %h want 4444", top_data); end
        tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL rot_n0_valid got %b want 1", res_valid); end
        issue(3'd7, 2'd1, 1'b0, 16'hFFFF);
        tests++; if (top_data !== 16'h4444 || res_valid !== 1'b1 || res_write !== 1'b0) begin
            fails++; $display("FAIL reserved_op got top=%h v=%b w=%b want top=4444 v=1 w=0", top_data, res_valid, res_write);
        end
    endtask

    task automatic test_clear();
        int low;
        issue(3'd5, 2'd0, 1'b0, 16'h0000);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clr_busy got %b want 1", busy); end
        // Hold a SWAP request while the clear runs.
        op_valid = 1'b1;
        op_code  = 3'd1;
        acc_in   = 16'h0077;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            if (op_ready === 1'b1) break;
            low++;
            idle_cycle();
        end
        tests++; if (low !== 4) begin fails++; $display("FAIL clr_ready_low got %0d cycles want 4", low); end
        tests++; if (res_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL clr_done got v=%b busy=%b want v=1 busy=0", res_valid, busy); end
        tests++; if (top_data !== 16'h0000) begin fails++; $display("FAIL clr_top got %h want 0000", top_data); end
        idle_cycle();
        op_valid = 1'b0;
        tests++; if (res_data !== 16'h0000 || res_write !== 1'b1) begin fails++; $display("FAIL held_swap got d=%h w=%b want d=0000 w=1", res_data, res_write); end
        tests++; if (top_data !== 16'h0077) begin fails++; $display("FAIL held_swap_top got %h want 0077", top_data); end
        issue(3'd2, 2'd0, 1'b0, 16'h0000);
        tests++; if (top_data !== 16'h0000) begin fails++; $display("FAIL clr_entry1 got %h want 0000", top_data); end
    endtask

    task automatic test_reset_mid_clear();
        issue(3'd1, 2'd0, 1'b0, 16'h1234);
        issue(3'd1, 2'd0, 1'b0, 16'h5678);
        tests++; if (res_data !== 16'h1234) begin fails++; $display("FAIL pre_rst_data got %h want 1234", res_data); end
        issue(3'd5, 2'd0, 1'b0, 16'h0000);
        idle_cycle();
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        tests++; if (op_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rst_clr_state got rdy=%b busy=%b want rdy=1 busy=0", op_ready, busy); end
        tests++; if (res_valid !== 1'b0 || res_write !== 1'b0) begin fails++; $display("FAIL rst_clr_resp got v=%b w=%b want 0 0", res_valid, res_write); end
        tests++; if (res_data !== 16'h0000 || top_data !== 16'h0000) begin fails++; $display("FAIL rst_clr_data got d=%h top=%h want 0000 0000", res_data, top_data); end
        issue(3'd4, 2'd2, 1'b0, 16'h0000);
        tests++; if (top_data !== 16'h0000) begin fails++; $display("FAIL rst_clr_entry2 got %h want 0000", top_data); end
    endtask

`ifdef MISAO_RSTACK_PARITY_EN
    task automatic test_parity();
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        issue(3'd1, 2'd0, 1'b0, 16'h000F);
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL parity_clean got %b want 0", parity_err); end
        dut.mem_q[0] = dut.mem_q[0] ^ 16'h0001;
        issue(3'd1, 2'd0, 1'b0, 16'h0000);
        tests++; if (parity_err !== 1'b1) begin fails++; $display("FAIL parity_set got %b want 1", parity_err); end
        issue(3'd1, 2'd0, 1'b0, 16'h0003);
        idle_cycle();
        tests++; if (parity_err !== 1'b1) begin fails++; $display("FAIL parity_sticky got %b want 1", parity_err); end
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL parity_rst got %b want 0", parity_err); end
    endtask
`endif

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        op_arg   = '0;
        lk16     = 1'b0;
        acc_in   = '0;
        test_reset();
        test_swap();
        test_rotate();
        test_lk16();
        test_rot_n();
        test_clear();
        test_reset_mid_clear();
`ifdef MISAO_RSTACK_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
